// File: rtl/instruction_fetch_if.sv
// Fetch-stage bundle: instruction-memory request/response, execute redirect,
// and the valid/ready handoff of fetched words to decode.
interface instruction_fetch_if #(
  parameter int unsigned XLEN = 64
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            instr_valid;
  logic            instr_ready;
  logic [31:0]     instruction;
  logic [XLEN-1:0] instr_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instruction, instr_pc,
    input  imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instruction, instr_pc,
    output imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, keeps one instruction-memory request in flight and
// hands each returned word plus its PC to decode; redirects squash stale words.
module instruction_fetch #(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] PC_RESET = '0
) (
  input logic                 clk,
  input logic                 reset,
  instruction_fetch_if.master bus
);

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic [XLEN-1:0] ipc_q, ipc_nxt;
  logic [31:0]     instr_q, instr_nxt;
  logic            kill, kill_nxt;
  logic [XLEN-1:0] redir_pc;

  assign redir_pc = {bus.redirect_pc[XLEN-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ISSUE;
      pc      <= PC_RESET;
      kill    <= 1'b0;
      instr_q <= '0;
      ipc_q   <= '0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      kill    <= kill_nxt;
      instr_q <= instr_nxt;
      ipc_q   <= ipc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    kill_nxt  = kill;
    instr_nxt = instr_q;
    ipc_nxt   = ipc_q;
    unique case (state)
      ISSUE: begin
        state_nxt = WAIT;
        // The request leaving this cycle already targets the old PC.
        if (bus.redirect_valid) begin
          pc_nxt   = redir_pc;
          kill_nxt = 1'b1;
        end
      end
      WAIT: begin
        if (bus.imem_rvalid) begin
          if (kill || bus.redirect_valid) begin
            kill_nxt  = 1'b0;
            state_nxt = ISSUE;
            if (bus.redirect_valid) pc_nxt = redir_pc;
          end else begin
            instr_nxt = bus.imem_rdata;
            ipc_nxt   = pc;
            pc_nxt    = pc + XLEN'(4);
            state_nxt = HOLD;
          end
        end else if (bus.redirect_valid) begin
          pc_nxt   = redir_pc;
          kill_nxt = 1'b1;
        end
      end
      HOLD: begin
        if (bus.redirect_valid) begin
          pc_nxt    = redir_pc;
          state_nxt = ISSUE;
        end else if (bus.instr_ready) begin
          state_nxt = ISSUE;
        end
      end
      default: state_nxt = ISSUE;
    endcase
  end

  assign bus.imem_req    = (state == ISSUE) && !reset;
  assign bus.imem_addr   = pc;
  assign bus.instr_valid = (state == HOLD);
  assign bus.instruction = instr_q;
  assign bus.instr_pc    = ipc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized scoreboard bench for instruction_fetch: a transaction-level model
// of the fetch protocol predicts request addresses and delivered words.
module tb_instruction_fetch;

  localparam logic [63:0] PC_RESET = 64'h0;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  instruction_fetch_if #(.XLEN(64)) bus_if ();

  instruction_fetch #(.XLEN(64), .PC_RESET(PC_RESET)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned passed = 0;

  // stimulus knobs
  int unsigned ready_pct     = 100;
  int unsigned redir_pct     = 0;
  int unsigned lat_fixed     = 1;
  bit          fixed_data_en = 1'b1;
  logic [31:0] fixed_data    = 32'h0050_0093;
  int unsigned rst_cycles    = 3;
  bit          force_redir   = 1'b0;
  logic [63:0] force_pc      = '0;
  int          resp_cnt      = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [63:0] pc;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h, required %h", nm, got, exp);
  endtask

  task automatic timeout_fail(input string nm);
    checks++;
    $display("FAIL %s: got no event within bound, required one", nm);
  endtask

  // input driver + memory responder (responses one or more cycles after the request)
  initial begin
    bus_if.imem_rvalid    = 1'b0;
    bus_if.imem_rdata     = '0;
    bus_if.redirect_valid = 1'b0;
    bus_if.redirect_pc    = '0;
    bus_if.instr_ready    = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus_if.imem_rvalid = 1'b0;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) bus_if.imem_rvalid = 1'b1;
      end
      reset = (rst_cycles > 0);
      if (rst_cycles > 0) rst_cycles--;
      // an in-flight response across reset arrives as a stale strobe right after
      if (reset && resp_cnt > 0) resp_cnt = 1;
      bus_if.imem_rdata = fixed_data_en ? fixed_data : 32'($urandom);
      if (force_redir) begin
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = force_pc;
        force_redir           = 1'b0;
      end else begin
        bus_if.redirect_valid = ($urandom_range(99) < redir_pct);
        if ($urandom_range(3) == 0) bus_if.redirect_pc = {32'($urandom), 32'($urandom)};
        else                        bus_if.redirect_pc = 64'($urandom_range(16'hFFFF));
      end
      bus_if.instr_ready = ($urandom_range(99) < ready_pct);
    end
  end

  always @(negedge clk) begin
    if (bus_if.imem_req)
      resp_cnt = (lat_fixed != 0) ? int'(lat_fixed) : int'($urandom_range(3, 1));
  end

  // reference model: one request outstanding, one word presented at a time
  bit          m_out      = 1'b0;
  bit          m_stale    = 1'b0;
  bit          m_pend     = 1'b0;
  bit          m_prev_rst = 1'b0;
  logic [63:0] m_pc       = PC_RESET;
  logic [63:0] m_addr     = '0;

  always @(negedge clk) begin
    bit exp_req;
    bit old_pend;
    exp_req = !reset && !m_out && !m_pend;
    check("imem_req", {63'd0, bus_if.imem_req}, {63'd0, exp_req});
    if (exp_req && bus_if.imem_req) check("imem_addr", bus_if.imem_addr, m_pc);
    check("instr_valid", {63'd0, bus_if.instr_valid}, {63'd0, m_pend});
    if (m_prev_rst) begin
      check("reset_instruction", {32'd0, bus_if.instruction}, 64'd0);
      check("reset_instr_pc", bus_if.instr_pc, 64'd0);
    end
    m_prev_rst = reset;
    if (reset) begin
      m_out  = 1'b0;
      m_pend = 1'b0;
      m_pc   = PC_RESET;
      exp_q.delete();
    end else begin
      old_pend = m_pend;
      if (exp_req) begin
        m_out   = 1'b1;
        m_addr  = m_pc;
        m_stale = 1'b0;
      end else if (m_out && bus_if.imem_rvalid) begin
        m_out = 1'b0;
        if (!m_stale && !bus_if.redirect_valid) begin
          exp_q.push_back('{data: bus_if.imem_rdata, pc: m_addr});
          m_pend = 1'b1;
          m_pc   = m_addr + 64'd4;
        end
      end
      if (old_pend) begin
        if (bus_if.redirect_valid) begin
          if (exp_q.size() > 0) void'(exp_q.pop_back());
          m_pend = 1'b0;
        end else if (bus_if.instr_ready) begin
          m_pend = 1'b0;
        end
      end
      if (bus_if.redirect_valid) begin
        m_pc = bus_if.redirect_pc & ~64'h3;
        if (m_out) m_stale = 1'b1;
      end
    end
  end

  // monitor: every word decode accepts must match the oldest expected word
  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus_if.instr_valid && bus_if.instr_ready && !bus_if.redirect_valid) begin
      if (exp_q.size() == 0) begin
        timeout_fail("accepted_word_expected");
      end else begin
        e = exp_q.pop_front();
        check("instruction", {32'd0, bus_if.instruction}, {32'd0, e.data});
        check("instr_pc", bus_if.instr_pc, e.pc);
      end
    end
  end

  task automatic wait_valid(input string nm, output bit ok);
    int unsigned n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus_if.instr_valid && n < 40);
    ok = bus_if.instr_valid;
    if (!ok) timeout_fail(nm);
  endtask

  task automatic wait_req(input string nm, output bit ok);
    int unsigned n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus_if.imem_req && n < 40);
    ok = bus_if.imem_req;
    if (!ok) timeout_fail(nm);
  endtask

  task automatic expect_req(input string nm, input logic [63:0] a);
    bit ok;
    wait_req(nm, ok);
    if (ok) check(nm, bus_if.imem_addr, a);
  endtask

  initial begin
    bit ok;
    int unsigned n;

    // first fetch latency with a single-cycle memory
    do @(negedge clk); while (reset);
    n = 0;
    while (!bus_if.instr_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("first_valid_cycle", 64'(n), 64'd2);
    check("first_instruction", {32'd0, bus_if.instruction}, 64'h0050_0093);
    check("first_instr_pc", bus_if.instr_pc, 64'h0);
    repeat (10) @(negedge clk);

    // decode stalls: word held, no new request
    ready_pct = 0;
    wait_valid("hold_valid", ok);
    if (ok) begin
      repeat (5) begin
        @(negedge clk);
        check("hold_valid_stays", {63'd0, bus_if.instr_valid}, 64'd1);
        check("hold_no_req", {63'd0, bus_if.imem_req}, 64'd0);
        if (exp_q.size() > 0) begin
          check("hold_instruction", {32'd0, bus_if.instruction}, {32'd0, exp_q[0].data});
          check("hold_instr_pc", bus_if.instr_pc, exp_q[0].pc);
        end else begin
          timeout_fail("hold_word_expected");
        end
      end
    end

    // redirect while the request is in flight
    ready_pct = 100;
    lat_fixed = 3;
    wait_req("redir_wait_req", ok);
    force_pc    = 64'h100;
    force_redir = 1'b1;
    expect_req("redir_wait_addr", 64'h100);
    wait_valid("redir_wait_valid", ok);
    if (ok) check("redir_wait_instr_pc", bus_if.instr_pc, 64'h100);

    // redirect coincident with the response
    lat_fixed = 2;
    wait_req("redir_rv_req", ok);
    @(negedge clk);
    force_pc    = 64'h200;
    force_redir = 1'b1;
    expect_req("redir_rv_addr", 64'h200);

    // redirect and ready together while holding; low bits ignored
    lat_fixed = 1;
    ready_pct = 0;
    wait_valid("redir_hold_valid", ok);
    force_pc    = 64'h103;
    force_redir = 1'b1;
    ready_pct   = 100;
    expect_req("redir_hold_addr", 64'h100);

    // PC wraps past the top of the address space
    ready_pct = 0;
    wait_valid("wrap_valid", ok);
    force_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    force_redir = 1'b1;
    ready_pct   = 100;
    expect_req("wrap_top_addr", 64'hFFFF_FFFF_FFFF_FFFC);
    expect_req("wrap_zero_addr", 64'h0);

    // reset during WAIT, stale response arrives the next cycle
    lat_fixed = 3;
    wait_req("rst_wait_req", ok);
    rst_cycles = 1;
    expect_req("rst_first_addr", PC_RESET);

    // randomized traffic
    fixed_data_en = 1'b0;
    lat_fixed     = 0;
    ready_pct     = 70;
    redir_pct     = 10;
    repeat (3000) @(negedge clk);
    redir_pct = 0;
    ready_pct = 100;
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
